// File: rtl/simple_comparison_arbiter.sv
// Round-robin arbiter in front of a shared two-stage unsigned compare pipeline.
// Results leave on a backpressured port and can raise one thread-flag write.
module simple_comparison_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32,
   parameter int FLAG_W = 3,
   parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*DATA_W-1:0]    req_a,
   input  logic [N_REQ*DATA_W-1:0]    req_b,
   input  logic [N_REQ*3-1:0]         req_op,
   input  logic [N_REQ*FLAG_W-1:0]    req_flag_idx,
   input  logic [N_REQ-1:0]           req_set_en,
   input  logic [N_REQ-1:0]           req_negate,
   input  logic [N_REQ-1:0]           req_cond_pass,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ID_W-1:0]            out_id,
   output logic                       out_result,
   output logic                       out_err,
   output logic                       flag_we,
   output logic [ID_W-1:0]            flag_thread,
   output logic [FLAG_W-1:0]          flag_idx,
   output logic                       flag_val
);

   logic [DATA_W-1:0] a_arr   [N_REQ];
   logic [DATA_W-1:0] b_arr   [N_REQ];
   logic [2:0]        op_arr  [N_REQ];
   logic [FLAG_W-1:0] idx_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign a_arr[g]   = req_a[g*DATA_W +: DATA_W];
      assign b_arr[g]   = req_b[g*DATA_W +: DATA_W];
      assign op_arr[g]  = req_op[g*3 +: 3];
      assign idx_arr[g] = req_flag_idx[g*FLAG_W +: FLAG_W];
   end

   function automatic logic compare(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b,
                                    input logic [2:0]        op);
      case (op)
         3'd0:    return a > b;
         3'd1:    return a < b;
         3'd2:    return a == b;
         3'd3:    return a != b;
         3'd4:    return a >= b;
         3'd5:    return a <= b;
         default: return 1'b0;
      endcase
   endfunction

   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   winner;
   logic              grant_valid;

   logic              s1_valid;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;
   logic [2:0]        s1_op;
   logic [FLAG_W-1:0] s1_flag_idx;
   logic              s1_set_en;
   logic              s1_negate;
   logic              s1_cond_pass;
   logic [ID_W-1:0]   s1_id;
   logic              s1_result;
   logic              s1_illegal;

   logic              s2_wr_en;
   logic [FLAG_W-1:0] s2_flag_idx;

   logic              s2_load;
   logic              s1_can_accept;
   logic              accept;

   // Scan ptr, ptr+1, ... with wrap; first valid requester wins.
   always_comb begin
      int              pos;
      logic [ID_W-1:0] cand;
      grant_valid = 1'b0;
      winner      = '0;
      pos         = 0;
      cand        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         pos  = (int'(ptr) + k) % N_REQ;
         cand = ID_W'(pos);
         if (!grant_valid && req_valid[cand]) begin
            grant_valid = 1'b1;
            winner      = cand;
         end
      end
   end

   assign s2_load       = s1_valid && (!out_valid || out_ready);
   assign s1_can_accept = !s1_valid || s2_load;
   assign accept        = rst_n && grant_valid && s1_can_accept;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[winner] = 1'b1;
   end

   assign s1_result  = compare(s1_a, s1_b, s1_op);
   assign s1_illegal = (s1_op > 3'd5);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr          <= '0;
         s1_valid     <= 1'b0;
         s1_a         <= '0;
         s1_b         <= '0;
         s1_op        <= '0;
         s1_flag_idx  <= '0;
         s1_set_en    <= 1'b0;
         s1_negate    <= 1'b0;
         s1_cond_pass <= 1'b0;
         s1_id        <= '0;
         out_valid    <= 1'b0;
         out_id       <= '0;
         out_result   <= 1'b0;
         out_err      <= 1'b0;
         s2_wr_en     <= 1'b0;
         s2_flag_idx  <= '0;
      end else begin
         if (accept) begin
            ptr          <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
            s1_valid     <= 1'b1;
            s1_a         <= a_arr[winner];
            s1_b         <= b_arr[winner];
            s1_op        <= op_arr[winner];
            s1_flag_idx  <= idx_arr[winner];
            s1_set_en    <= req_set_en[winner];
            s1_negate    <= req_negate[winner];
            s1_cond_pass <= req_cond_pass[winner];
            s1_id        <= winner;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end

         if (s2_load) begin
            out_valid   <= 1'b1;
            out_id      <= s1_id;
            out_result  <= s1_result ^ s1_negate;
            out_err     <= s1_illegal;
            s2_wr_en    <= s1_set_en && s1_cond_pass && !s1_illegal;
            s2_flag_idx <= s1_flag_idx;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // The write fires only on the handshake cycle, so a stalled result cannot write twice.
   assign flag_we     = rst_n && out_valid && out_ready && s2_wr_en;
   assign flag_thread = out_id;
   assign flag_idx    = s2_flag_idx;
   assign flag_val    = out_result;

endmodule

// File: tb/tb_simple_comparison_arbiter.sv
// Directed bench for simple_comparison_arbiter: each task drives one scenario
// and compares outputs against hand-computed values.
module tb_simple_comparison_arbiter;
   localparam int N_REQ  = 4;
   localparam int DATA_W = 32;
   localparam int FLAG_W = 3;
   localparam int ID_W   = 2;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*DATA_W-1:0] req_a;
   logic [N_REQ*DATA_W-1:0] req_b;
   logic [N_REQ*3-1:0]      req_op;
   logic [N_REQ*FLAG_W-1:0] req_flag_idx;
   logic [N_REQ-1:0]        req_set_en;
   logic [N_REQ-1:0]        req_negate;
   logic [N_REQ-1:0]        req_cond_pass;
   logic                    out_valid;
   logic                    out_ready;
   logic [ID_W-1:0]         out_id;
   logic                    out_result;
   logic                    out_err;
   logic                    flag_we;
   logic [ID_W-1:0]         flag_thread;
   logic [FLAG_W-1:0]       flag_idx;
   logic                    flag_val;

   int checks = 0;
   int errors = 0;

   // {valid, id, result, err} and {we, thread, idx, val}
   logic [4:0] out_obs;
   logic [6:0] flag_obs;
   assign out_obs  = {out_valid, out_id, out_result, out_err};
   assign flag_obs = {flag_we, flag_thread, flag_idx, flag_val};

   simple_comparison_arbiter #(
      .N_REQ(N_REQ), .DATA_W(DATA_W), .FLAG_W(FLAG_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .req_flag_idx(req_flag_idx), .req_set_en(req_set_en),
      .req_negate(req_negate), .req_cond_pass(req_cond_pass),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_id(out_id), .out_result(out_result), .out_err(out_err),
      .flag_we(flag_we), .flag_thread(flag_thread),
      .flag_idx(flag_idx), .flag_val(flag_val)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic set_cmd(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [2:0] idx,
                          input logic se, input logic neg, input logic cp);
      req_a[i*DATA_W +: DATA_W]     = a;
      req_b[i*DATA_W +: DATA_W]     = b;
      req_op[i*3 +: 3]              = op;
      req_flag_idx[i*FLAG_W +: FLAG_W] = idx;
      req_set_en[i]    = se;
      req_negate[i]    = neg;
      req_cond_pass[i] = cp;
   endtask

   // Presents one command from an idle pipe and returns in its output cycle.
   task automatic send_one(input int i);
      req_valid = 4'b0001 << i;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req_valid = '1; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
      checks++; if (out_obs !== 5'b0) begin errors++; $display("FAIL reset_out got %b exp 00000", out_obs); end
      checks++; if (flag_obs !== 7'b0) begin errors++; $display("FAIL reset_flag got %b exp 0000000", flag_obs); end
      req_valid = '0; rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single;
      set_cmd(0, 5, 3, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1);
      req_valid = 4'b0001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", out_valid); end
      @(negedge clk);
      #1;
      checks++; if (out_obs !== {1'b1, 2'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL single_out got %b exp 10010", out_obs); end
      checks++; if (flag_obs !== {1'b1, 2'd0, 3'd2, 1'b1}) begin errors++; $display("FAIL single_flag got %b exp 1000101", flag_obs); end
      @(negedge clk);
      #1;
      checks++; if ({out_valid, flag_we} !== 2'b00) begin errors++; $display("FAIL single_after got %b exp 00", {out_valid, flag_we}); end
   endtask

   task automatic test_unsigned_negate;
      set_cmd(0, 32'hFFFF_FFFF, 32'h0, 3'd1, 3'd5, 1'b1, 1'b1, 1'b1);
      send_one(0);
      checks++; if (out_obs !== {1'b1, 2'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL uns_lt_neg_out got %b exp 10010", out_obs); end
      checks++; if (flag_obs !== {1'b1, 2'd0, 3'd5, 1'b1}) begin errors++; $display("FAIL uns_lt_neg_flag got %b exp 1001011", flag_obs); end
      set_cmd(1, 7, 7, 3'd5, 3'd3, 1'b1, 1'b1, 1'b1);
      send_one(1);
      checks++; if (out_obs !== {1'b1, 2'd1, 1'b0, 1'b0}) begin errors++; $display("FAIL le_neg_out got %b exp 10100", out_obs); end
      checks++; if (flag_obs !== {1'b1, 2'd1, 3'd3, 1'b0}) begin errors++; $display("FAIL le_neg_flag got %b exp 1010110", flag_obs); end
      set_cmd(2, 32'hFFFF_FFFF, 32'h0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1);
      send_one(2);
      checks++; if (out_obs !== {1'b1, 2'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL uns_gt_out got %b exp 11010", out_obs); end
   endtask

   task automatic test_equal_ops;
      logic [5:0] exp_eq;
      exp_eq = 6'b110100;
      for (int op = 0; op < 6; op++) begin
         set_cmd(3, 9, 9, 3'(op), 3'(op), 1'b1, 1'b0, 1'b1);
         send_one(3);
         checks++; if (out_obs !== {1'b1, 2'd3, exp_eq[op], 1'b0}) begin errors++; $display("FAIL equal_op%0d_out got %b exp %b", op, out_obs, {1'b1, 2'd3, exp_eq[op], 1'b0}); end
         checks++; if (flag_obs !== {1'b1, 2'd3, 3'(op), exp_eq[op]}) begin errors++; $display("FAIL equal_op%0d_flag got %b exp %b", op, flag_obs, {1'b1, 2'd3, 3'(op), exp_eq[op]}); end
      end
   endtask

   task automatic test_round_robin;
      int g [14];
      int e;
      for (int i = 0; i < N_REQ; i++) set_cmd(i, 32'(i), 1, 3'd0, 3'(i), 1'b0, 1'b0, 1'b1);
      req_valid = '1;
      for (int k = 0; k < 14; k++) begin
         if (k == 8)  req_valid = 4'b1010;
         if (k == 12) req_valid = 4'b0000;
         #1;
         if (k < 12) begin
            e = (k < 8) ? (k % 4) : ((k % 2 == 1) ? 3 : 1);
            g[k] = e;
            checks++; if (req_ready !== (4'b0001 << e)) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, 4'b0001 << e); end
         end
         if (k >= 2) begin
            checks++; if (out_obs !== {1'b1, 2'(g[k-2]), (g[k-2] > 1), 1'b0}) begin errors++; $display("FAIL rr_out%0d got %b exp %b", k, out_obs, {1'b1, 2'(g[k-2]), (g[k-2] > 1), 1'b0}); end
            checks++; if (flag_we !== 1'b0) begin errors++; $display("FAIL rr_flag_we%0d got %b exp 0", k, flag_we); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure;
      set_cmd(0, 10, 20, 3'd1, 3'd1, 1'b1, 1'b0, 1'b1);
      set_cmd(1, 10, 20, 3'd0, 3'd4, 1'b1, 1'b0, 1'b1);
      set_cmd(2, 3,  3,  3'd2, 3'd7, 1'b1, 1'b0, 1'b1);
      out_ready = 1'b0;
      req_valid = 4'b0111;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0 got %b exp 0001", req_ready); end
      @(negedge clk);
      req_valid = 4'b0110;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1 got %b exp 0010", req_ready); end
      @(negedge clk);
      req_valid = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d got %b exp 0000", c, req_ready); end
         checks++; if (out_obs !== {1'b1, 2'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL bp_hold%0d got %b exp 10010", c, out_obs); end
         checks++; if (flag_we !== 1'b0) begin errors++; $display("FAIL bp_flag_we%0d got %b exp 0", c, flag_we); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_grant got %b exp 0100", req_ready); end
      checks++; if (out_obs !== {1'b1, 2'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL bp_drain0_out got %b exp 10010", out_obs); end
      checks++; if (flag_obs !== {1'b1, 2'd0, 3'd1, 1'b1}) begin errors++; $display("FAIL bp_drain0_flag got %b exp 1000011", flag_obs); end
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++; if (out_obs !== {1'b1, 2'd1, 1'b0, 1'b0}) begin errors++; $display("FAIL bp_drain1_out got %b exp 10100", out_obs); end
      checks++; if (flag_obs !== {1'b1, 2'd1, 3'd4, 1'b0}) begin errors++; $display("FAIL bp_drain1_flag got %b exp 1011000", flag_obs); end
      @(negedge clk);
      #1;
      checks++; if (out_obs !== {1'b1, 2'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL bp_drain2_out got %b exp 11010", out_obs); end
      checks++; if (flag_obs !== {1'b1, 2'd2, 3'd7, 1'b1}) begin errors++; $display("FAIL bp_drain2_flag got %b exp 1101111", flag_obs); end
      @(negedge clk);
      #1;
      checks++; if ({out_valid, flag_we} !== 2'b00) begin errors++; $display("FAIL bp_empty got %b exp 00", {out_valid, flag_we}); end
   endtask

   task automatic test_gating;
      set_cmd(2, 8, 4, 3'd0, 3'd6, 1'b1, 1'b0, 1'b0);
      send_one(2);
      checks++; if (out_obs !== {1'b1, 2'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL gate_cond_out got %b exp 11010", out_obs); end
      checks++; if (flag_we !== 1'b0) begin errors++; $display("FAIL gate_cond_we got %b exp 0", flag_we); end
      set_cmd(2, 8, 4, 3'd3, 3'd6, 1'b0, 1'b0, 1'b1);
      send_one(2);
      checks++; if (out_obs !== {1'b1, 2'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL gate_seten_out got %b exp 11010", out_obs); end
      checks++; if (flag_we !== 1'b0) begin errors++; $display("FAIL gate_seten_we got %b exp 0", flag_we); end
      set_cmd(2, 8, 4, 3'd6, 3'd6, 1'b1, 1'b0, 1'b1);
      send_one(2);
      checks++; if (out_obs !== {1'b1, 2'd2, 1'b0, 1'b1}) begin errors++; $display("FAIL gate_op6_out got %b exp 11001", out_obs); end
      checks++; if (flag_we !== 1'b0) begin errors++; $display("FAIL gate_op6_we got %b exp 0", flag_we); end
      set_cmd(2, 3, 3, 3'd7, 3'd6, 1'b1, 1'b0, 1'b1);
      send_one(2);
      checks++; if (out_obs !== {1'b1, 2'd2, 1'b0, 1'b1}) begin errors++; $display("FAIL gate_op7_out got %b exp 11001", out_obs); end
      checks++; if (flag_we !== 1'b0) begin errors++; $display("FAIL gate_op7_we got %b exp 0", flag_we); end
   endtask

   task automatic test_reset_midflight;
      set_cmd(0, 1, 2, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1);
      set_cmd(1, 1, 2, 3'd1, 3'd1, 1'b1, 1'b0, 1'b1);
      set_cmd(2, 4, 4, 3'd4, 3'd5, 1'b1, 1'b0, 1'b1);
      out_ready = 1'b1;
      req_valid = 4'b0001;
      @(negedge clk);
      req_valid = 4'b0010;
      @(negedge clk);
      req_valid = '1;
      rst_n = 1'b0;
      #1;
      checks++; if (flag_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we got %b exp 0", flag_we); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b exp 0000", req_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = '0;
      #1;
      checks++; if (out_obs !== 5'b0) begin errors++; $display("FAIL mid_post_out got %b exp 00000", out_obs); end
      checks++; if (flag_obs !== 7'b0) begin errors++; $display("FAIL mid_post_flag got %b exp 0000000", flag_obs); end
      @(negedge clk);
      #1;
      checks++; if ({out_valid, flag_we} !== 2'b00) begin errors++; $display("FAIL mid_discard got %b exp 00", {out_valid, flag_we}); end
      req_valid = 4'b0101;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr_zero got %b exp 0001", req_ready); end
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_req2_grant got %b exp 0100", req_ready); end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
      checks++; if (out_obs !== {1'b1, 2'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL mid_req2_out got %b exp 11010", out_obs); end
      checks++; if (flag_obs !== {1'b1, 2'd2, 3'd5, 1'b1}) begin errors++; $display("FAIL mid_req2_flag got %b exp 1101011", flag_obs); end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; out_ready = 1'b1;
      req_a = '0; req_b = '0; req_op = '0; req_flag_idx = '0;
      req_set_en = '0; req_negate = '0; req_cond_pass = '0;
      test_reset;
      test_single;
      test_unsigned_negate;
      test_equal_ops;
      test_round_robin;
      test_backpressure;
      test_gating;
      test_reset_midflight;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/simple_comparison_arbiter.md
Name: simple_comparison_arbiter

Overview:
- Shares one unsigned compare datapath between N_REQ thread requesters. Each requester issues a compare command: operands, compare op, target flag, negate, set-enable and a pre-evaluated conditional-gate bit.
- Arbitrates round-robin, pipelines the compare over two stages and returns the result on a backpressured output.
- Drives a single thread-flag write port into the execution-environment flag file.

Parameters:
- N_REQ, 4, number of requesters; ID_W = max(1, clog2(N_REQ)), derived.
- DATA_W, 32, operand width (unsigned).
- FLAG_W, 3, flag index width (2^FLAG_W flags per thread).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  N_REQ  per-requester command valid.
- req_ready  out  N_REQ  per-requester accept.
- req_a  in  N_REQ*DATA_W  operand A, slice i for requester i.
- req_b  in  N_REQ*DATA_W  operand B.
- req_op  in  N_REQ*3  compare op: 0 A>B, 1 A<B, 2 A==B, 3 A!=B, 4 A>=B, 5 A<=B; 6-7 illegal.
- req_flag_idx  in  N_REQ*FLAG_W  target flag.
- req_set_en  in  N_REQ  write flag when gate passes.
- req_negate  in  N_REQ  invert result before write/output.
- req_cond_pass  in  N_REQ  conditional-flag gate, already evaluated by requester.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accept.
- out_id  out  ID_W  requester index.
- out_result  out  1  final (post-negate) compare bit.
- out_err  out  1  illegal op.
- flag_we  out  1  flag write strobe.
- flag_thread  out  ID_W  thread (= requester) written.
- flag_idx  out  FLAG_W  flag written.
- flag_val  out  1  value written.

Behaviour:
- Reset (rst_n=0 at rising edge): all pipeline valids 0, RR pointer 0. All outputs 0; req_ready all 0 during reset cycle.
- Arbitration (comb): eligible = req_valid. Winner is first eligible index scanning ptr, ptr+1, ..., wrapping mod N_REQ. req_ready is one-hot at winner iff stage1 can accept, else all 0. No requester sees ready without valid.
- Stage1 accepts when s1 empty, or s1 moves to s2 this cycle.
- On accept (valid&ready, cycle T): latch a, b, op, flag_idx, set_en, negate, cond_pass, id into s1; ptr <= winner+1 mod N_REQ. Pointer does not move without an accept.
- Stage2 (output register) loads from s1 when empty or when out_valid&&out_ready. Computes:
  - R = unsigned compare per op.
  - Illegal op: R=0, out_err=1, flag write suppressed.
  - out_result = R ^ negate (negate is logical inversion).
- Latency: accept in T -> out_valid in T+2 with no backpressure. Throughput is 1 result/cycle.
- Backpressure: out_valid && !out_ready holds all out_*/s2 stable. s1 holds if s2 full and stalled. req_ready deasserts when s1 full and stalled. No command is dropped or duplicated.
- Flag write: flag_we=1 for exactly one cycle, the cycle out_valid&&out_ready, iff set_en && cond_pass && !err. flag_thread=out_id, flag_idx/flag_val=latched/out_result. flag_we=0 at all other times. flag_thread/idx/val are don't-care when flag_we=0 but must equal 0 after reset.
- cond_pass=0: result still returned on out_*, no flag write.
- Simultaneous accept into s1 and drain of s2 in the same cycle is legal. Full pipeline sustains back-to-back.
- rst_n low mid-operation: in-flight commands discarded, no flag_we in or after the reset cycle until new accepts.
- Equal operands: ops 2, 4, 5 -> 1; ops 0, 1, 3 -> 0. Compare is unsigned: 0xFFFFFFFF > 0.

Test Plan:
- Single command: req0 a=5, b=3, op=0, set_en=1, cond_pass=1, flag_idx=2, out_ready=1 -> out_valid 2 cycles after accept, out_id=0, out_result=1, flag_we pulse thread0 idx2 val1.
- Unsigned/negate: a=0xFFFFFFFF, b=0, op=1, negate=1 -> out_result=1, flag_val=1. Same with op=5, a=b=7, negate=1 -> 0.
- Round-robin: all 4 req_valid held for 8 accepts -> grant order 0,1,2,3,0,1,2,3. Then req1 and req3 only, ptr=0 -> 1,3,1,3.
- Backpressure: 3 back-to-back commands, out_ready=0 for 5 cycles -> out_* stable, req_ready drops once s1 full. On release, results drain in order, one flag_we per result, none lost.
- Gating: cond_pass=0 or set_en=0 -> out_valid with correct result, flag_we never asserts. op=6 -> out_err=1, out_result=0, no flag_we.
- Reset mid-flight: 2 commands in pipe, rst_n=0 one cycle -> out_valid=0, flag_we=0, ptr=0. Next request from req2 alone granted normally.
